shift_arbiter16: RTL and testbench
==================================

SHIFT_ARBITER16 -- requirements
Module: shift_arbiter16

Interface
REQ-001 Parameter: W, default 16, data width of operand and result (shift amount field is clog2(W) = 4 bits).
REQ-002 Ports: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-006 req0_a  input  W  requester 0 operand.
REQ-007 req0_b  input  W  requester 0 shift amount (full 16-bit field).
REQ-008 req0_ready  output  1  request 0 accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_a, req1_b, req1_ready  same directions, widths and meanings as for requester 0.
REQ-010 out_valid  output  1  result held on out_data.
REQ-011 out_data  output  W  shifted result.
REQ-012 out_id  output  1  index of the requester that owns out_data.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Computation: out_data = a << b, logical, zero-filled; any b >= 16 (any bit above bit 3 set) gives out_data = 0.
REQ-015 FSM states: IDLE (no result held) and HOLD (result registered, out_valid=1).
REQ-016 IDLE: if either valid is high, grant exactly one requester, register its result and id, assert that requester's ready for that cycle, then go to HOLD.
REQ-017 HOLD with out_ready=0: out_valid, out_data and out_id are stable; both readies are 0.
REQ-018 HOLD with out_ready=1 and any valid high: retire the current result and accept a new grant in the same cycle; stay in HOLD. This gives one operation per cycle.
REQ-019 HOLD with out_ready=1 and no valid high: go to IDLE; out_valid=0 next cycle.
REQ-020 Latency: result appears on out_data one cycle after the acceptance edge.
REQ-021 At most one ready is high per cycle; ready is never high while the corresponding valid is low.
REQ-022 Requesters hold valid, a and b stable until ready is high; the block never drops a request.
REQ-023 out_data and out_id are don't-care while out_valid=0 and hold their last value.

Reset
REQ-024 rst=1 forces, asynchronously: state=IDLE, out_valid=0, out_data=0, out_id=0, round-robin pointer = requester 0, req0_ready=0, req1_ready=0.
REQ-025 Reset mid-HOLD discards the held result; no completion is reported for it.
REQ-026 The first grant after reset release follows REQ-027/REQ-028 with the pointer at 0.

Configuration
REQ-027 Macro SHIFT_ARB_RR_EN defined: round-robin arbitration.
- On a simultaneous request, the requester not granted last wins.
- The pointer updates only on a grant.
REQ-028 Macro SHIFT_ARB_RR_EN undefined: fixed priority, requester 0 always wins.
- Requester 1 is granted only when req0_valid=0.
- No pointer register is synthesised.

Structure
REQ-029 Package shift_arb_pkg SHALL hold:
- the state enum (IDLE, HOLD);
- constants W=16 and SHAMT_W=4;
- the requester-id type.
REQ-030 Sub-module rr_arb2: 2-way arbiter with inputs valid[1:0] and grant_en and outputs grant one-hot and gid; it contains the pointer and the macro-dependent logic.
REQ-031 The shift itself is combinational inside shift_arbiter16; only the result, id and state are registered.

Verification
REQ-032 Reset then req0 a=0x0001, b=0x0001 -> out_valid=1 next cycle, out_data=0x0002, out_id=0.
REQ-033 req1 a=0x0001, b=0x000F -> out_data=0x8000; req1 b=0x0010 -> out_data=0x0000.
REQ-034 Both valid continuously, out_ready=1:
- with SHIFT_ARB_RR_EN, grants alternate 0,1,0,1 and one result is produced per cycle;
- without the macro, requester 0 only.
REQ-035 out_ready=0 for 5 cycles in HOLD:
- out_data and out_id are unchanged;
- both readies are 0;
- no request is lost once out_ready=1.
REQ-036 Assert rst during HOLD with out_data=0x00F0 -> out_valid=0 and out_data=0 immediately (asynchronously); the next request completes normally.
REQ-037 Continuous assertion checks: at most one ready high; no ready without its valid; out_data equals (a << b) of the accepted operands, or 0 when b >= 16.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter16 codebase slice:
// FSM state enum, data/shift-amount widths and the requester id type.
package shift_arb_pkg;

  localparam int W       = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter for shift_arbiter16.
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration; without it
// requester 0 has fixed priority and no pointer register exists.
// Handshake: grant[i] is only ever high when valid[i] and grant_en are high,
// and at most one grant bit is high; gid is the index of the chosen requester.
module rr_arb2
  import shift_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic [1:0] grant,
  output req_id_t    gid
);

`ifdef SHIFT_ARB_RR_EN
  // ptr names the requester that wins a tie; it moves only on a real grant
  req_id_t ptr;

  // Pointer register: after granting i, the other requester gets the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= ~gid;
    end
  end

  // Select winner: tie goes to ptr, otherwise the lone requester
  always_comb begin
    gid = 1'b0;
    if (valid == 2'b11) begin
      gid = ptr;
    end else if (valid[1]) begin
      gid = 1'b1;
    end
  end
`else
  // Fixed priority has no state; clk/rst are kept for a uniform interface
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Select winner: requester 0 always wins when it is requesting
  always_comb begin
    gid = 1'b0;
    if (!valid[0] && valid[1]) begin
      gid = 1'b1;
    end
  end
`endif

  // Turn the chosen id into a one-hot grant, only when granting is allowed
  always_comb begin
    grant = 2'b00;
    if (grant_en && (|valid)) begin
      grant = gid ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/shift_arbiter16.sv
// shift_arbiter16: two requesters share one logical left shifter.
// Build option: SHIFT_ARB_RR_EN selects round-robin arbitration (inside rr_arb2);
// default build uses fixed priority for requester 0.
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
// a result transfers where out_valid && out_ready. Requesters hold valid/a/b
// until ready; the result is held stable on out_data/out_id until out_ready.
// The FSM state is visible on dbg_state.
module shift_arbiter16
  import shift_arb_pkg::*;
#(
  parameter int W = shift_arb_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output req_id_t      out_id,
  input  logic         out_ready,
  output state_t       dbg_state
);

  localparam int SW = $clog2(W);

  state_t       state;
  state_t       state_nx;
  logic [1:0]   grant;
  req_id_t      gid;
  logic         grant_en;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [W-1:0] shift_res;

  // A new grant is allowed when nothing is held or the held result retires now
  assign grant_en = (state == IDLE) || out_ready;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    ({req1_valid, req0_valid}),
    .grant_en (grant_en),
    .grant    (grant),
    .gid      (gid)
  );

  // Operand mux and logical shift; any amount bit above the low SW bits zeroes the result
  always_comb begin
    sel_a     = gid ? req1_a : req0_a;
    sel_b     = gid ? req1_b : req0_b;
    shift_res = '0;
    if (sel_b[W-1:SW] == '0) begin
      shift_res = sel_a << sel_b[SW-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: any grant lands in HOLD; a retire with no new grant returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (|grant) state_nx = HOLD;
      HOLD: if (out_ready && !(|grant)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state and the arbiter grant
  always_comb begin
    out_valid  = (state == HOLD);
    req0_ready = grant[0];
    req1_ready = grant[1];
    dbg_state  = state;
  end

  // Result and owner id captured on every grant, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_id   <= 1'b0;
    end else if (|grant) begin
      out_data <= shift_res;
      out_id   <= gid;
    end
  end

endmodule

// File: tb/tb_shift_arbiter16.sv
// Self-checking bench for shift_arbiter16 (works with or without SHIFT_ARB_RR_EN).
module tb_shift_arbiter16;
  import shift_arb_pkg::*;

  localparam int DW = 16;
`ifdef SHIFT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_id;
  logic          out_ready;
  state_t        dbg_state;

  always #5 clk = ~clk;

  shift_arbiter16 #(.W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  int   ptr_m;       // requester that wins a tie next (round-robin only)
  bit   holding_m;   // a result is currently owed on the output
  logic [DW:0] exp_q[$];  // {id, data} of accepted operations not yet retired

  // a << b as plain arithmetic: multiply by 2^b and keep the low 16 bits
  function automatic logic [DW-1:0] ref_shift(logic [DW-1:0] a, logic [DW-1:0] b);
    longint p;
    if (b >= 16) return '0;
    p = longint'(a) * (longint'(1) << b);
    return DW'(p % 65536);
  endfunction

  // Which requester the arbitration rules pick, given who is asking
  function automatic int pick(bit v0, bit v1, int ptr);
    if (v0 && v1) return RR ? ptr : 0;
    return v0 ? 0 : 1;
  endfunction

  function automatic logic [DW-1:0] rand_b();
    if ($urandom_range(0, 3) == 0) return DW'($urandom_range(16, 65535));
    return DW'($urandom_range(0, 15));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ptr_m = 0; holding_m = 0; exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id got %b exp 0", out_id); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready}); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    apply_reset();
  endtask

  // Directed shifts: 1<<1, 1<<15, 1<<16
  task automatic test_basic();
    logic [DW-1:0] ta [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic [DW-1:0] tb [3] = '{16'h0001, 16'h000F, 16'h0010};
    logic [DW-1:0] te [3] = '{16'h0002, 16'h8000, 16'h0000};
    bit            ti [3] = '{1'b0, 1'b1, 1'b1};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      if (ti[i]) begin req1_valid = 1; req1_a = ta[i]; req1_b = tb[i]; end
      else       begin req0_valid = 1; req0_a = ta[i]; req0_b = tb[i]; end
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== (ti[i] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL basic_ready[%0d] got %b exp %b", i, {req1_ready, req0_ready}, ti[i] ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      ptr_m = ti[i] ? 0 : 1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_data !== te[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, out_data, te[i]); end
      checks++; if (out_id !== ti[i]) begin errors++; $display("FAIL basic_id[%0d] got %b exp %b", i, out_id, ti[i]); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", out_valid); end
  endtask

  // Both requesters always asking, consumer always ready: one result per cycle
  task automatic test_back_to_back();
    int g;
    logic [DW-1:0] ea, eb;
    req0_valid = 1; req0_a = DW'($urandom); req0_b = rand_b();
    req1_valid = 1; req1_a = DW'($urandom); req1_b = rand_b();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      g = pick(1'b1, 1'b1, ptr_m);
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== (g == 1 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_grant[%0d] got %b exp %b", i, {req1_ready, req0_ready}, g == 1 ? 2'b10 : 2'b01);
      end
      ea = (g == 1) ? req1_a : req0_a;
      eb = (g == 1) ? req1_b : req0_b;
      @(posedge clk); #1;
      ptr_m = 1 - g;
      if (g == 1) begin req1_a = DW'($urandom); req1_b = rand_b(); end
      else        begin req0_a = DW'($urandom); req0_b = rand_b(); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== ref_shift(ea, eb) || out_id !== 1'(g)) begin
        errors++; $display("FAIL b2b_result[%0d] got v%b %h id%b exp v1 %h id%0d", i, out_valid, out_data, out_id, ref_shift(ea, eb), g);
      end
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
  endtask

  // Consumer stalls 5 cycles with both requests pending; nothing moves, nothing lost
  task automatic test_backpressure();
    logic [DW-1:0] held;
    logic [DW-1:0] ea, eb;
    int g;
    req0_valid = 1; req0_a = DW'($urandom); req0_b = DW'($urandom_range(0, 15));
    out_ready = 1;
    held = ref_shift(req0_a, req0_b);
    @(negedge clk);
    @(posedge clk); #1;
    ptr_m = 1;
    out_ready = 0;
    req0_a = DW'($urandom); req0_b = rand_b();
    req1_valid = 1; req1_a = DW'($urandom); req1_b = rand_b();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00 || out_valid !== 1'b1 || out_data !== held || out_id !== 1'b0) begin
        errors++; $display("FAIL stall[%0d] got rdy%b v%b %h id%b exp rdy00 v1 %h id0", i, {req1_ready, req0_ready}, out_valid, out_data, out_id, held);
      end
    end
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      g = pick(req0_valid, req1_valid, ptr_m);
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== (g == 1 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL drain_grant[%0d] got %b exp %b", i, {req1_ready, req0_ready}, g == 1 ? 2'b10 : 2'b01);
      end
      ea = (g == 1) ? req1_a : req0_a;
      eb = (g == 1) ? req1_b : req0_b;
      @(posedge clk); #1;
      ptr_m = 1 - g;
      if (g == 1) req1_valid = 0; else req0_valid = 0;
      checks++;
      if (out_data !== ref_shift(ea, eb) || out_id !== 1'(g)) begin
        errors++; $display("FAIL drain_result[%0d] got %h id%b exp %h id%0d", i, out_data, out_id, ref_shift(ea, eb), g);
      end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", out_valid); end
  endtask

  // Reset between edges while a result is held, then a fresh request
  task automatic test_reset_mid_hold();
    req0_valid = 1; req0_a = 16'h000F; req0_b = 16'h0004; out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; out_ready = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00F0) begin errors++; $display("FAIL pre_rst got v%b %h exp v1 00f0", out_valid, out_data); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 1'b0) begin
      errors++; $display("FAIL async_rst got v%b %h id%b exp v0 0000 id0", out_valid, out_data, out_id);
    end
    @(posedge clk); #1 rst = 1'b0;
    ptr_m = 0; holding_m = 0;
    req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0002; out_ready = 1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL post_rst_grant got %b exp 10", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req1_valid = 0; ptr_m = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h000C || out_id !== 1'b1) begin errors++; $display("FAIL post_rst_result got v%b %h id%b exp v1 000c id1", out_valid, out_data, out_id); end
    @(posedge clk); #1;
  endtask

  // Random traffic and random consumer stalls, scoreboarded through exp_q
  task automatic test_random();
    int g;
    bit ga;
    logic [1:0] exp_rdy;
    logic [DW-1:0] ea, eb;
    logic [DW:0] front;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        if (!req0_valid && $urandom_range(0, 1) == 1) begin req0_valid = 1; req0_a = DW'($urandom); req0_b = rand_b(); end
        if (!req1_valid && $urandom_range(0, 1) == 1) begin req1_valid = 1; req1_a = DW'($urandom); req1_b = rand_b(); end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== holding_m) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", cyc, out_valid, holding_m); end
      if (holding_m && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_retire[%0d] got %h id%b exp none", cyc, out_data, out_id);
        end else begin
          front = exp_q.pop_front();
          if ({out_id, out_data} !== front) begin
            errors++; $display("FAIL rnd_retire[%0d] got %h id%b exp %h id%b", cyc, out_data, out_id, front[DW-1:0], front[DW]);
          end
        end
      end
      ga = (!holding_m || out_ready) && (req0_valid || req1_valid);
      g = pick(req0_valid, req1_valid, ptr_m);
      exp_rdy = ga ? (g == 1 ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", cyc, {req1_ready, req0_ready}, exp_rdy);
      end
      ea = (g == 1) ? req1_a : req0_a;
      eb = (g == 1) ? req1_b : req0_b;
      @(posedge clk); #1;
      if (ga) begin
        exp_q.push_back({1'(g), ref_shift(ea, eb)});
        holding_m = 1; ptr_m = 1 - g;
        if (g == 1) req1_valid = 0; else req0_valid = 0;
      end else if (out_ready) begin
        holding_m = 0;
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || req0_valid || req1_valid) begin
      errors++; $display("FAIL rnd_drain got q%0d v%b p%b%b exp q0 v0 p00", exp_q.size(), out_valid, req1_valid, req0_valid);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_hold();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
